// File: rtl/alu_exec_if.sv
// Handshake and data bundle between the EX-stage controller and the ALU execution unit.
// The master side issues operations. The slave side returns results and status flags.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, hi, lo, zero, overflow, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, hi, lo, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith ops plus an iterative shift-add unsigned multiplier.
// A registered done pulse marks each completion; busy lets the controller stall during MULTU.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_exec_if.slave    bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpMulu = 4'b1000;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             zero_q;
    logic             overflow_q;
    logic             illegal_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  count_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] b_neg;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mplier_nxt;

    // Single-cycle datapath
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        b_neg   = ~bus.b + WIDTH'(1);
        sum     = bus.a + bus.b;
        diff    = bus.a + b_neg;
        case (bus.op)
            OpAnd: alu_res = bus.a & bus.b;
            OpOr:  alu_res = bus.a | bus.b;
            OpNor: alu_res = ~(bus.a | bus.b);
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] == b_neg[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_ill = 1'b1;
        endcase
    end

    // One multiplier step: conditional add into the upper half, then shift {carry,acc,mplier} right
    always_comb begin
        step_sum   = mplier_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        acc_nxt    = step_sum[WIDTH:1];
        mplier_nxt = {step_sum[0], mplier_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            count_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.op == OpMulu) begin
                            mcand_q  <= bus.a;
                            mplier_q <= bus.b;
                            acc_q    <= '0;
                            count_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= StMul;
                        end else begin
                            result_q   <= alu_res;
                            zero_q     <= (alu_res == '0);
                            overflow_q <= alu_ovf;
                            illegal_q  <= alu_ill;
                            done_q     <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    acc_q    <= acc_nxt;
                    mplier_q <= mplier_nxt;
                    count_q  <= count_q + CntW'(1);
                    if (count_q == CntW'(WIDTH - 1)) begin
                        hi_q       <= acc_nxt;
                        lo_q       <= mplier_nxt;
                        result_q   <= mplier_nxt;
                        zero_q     <= (mplier_nxt == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit. Expected values are computed by hand.
module tb_alu_exec_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 4'b0000; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++; if ({bus.hi, bus.lo} !== '0) begin errors++; $display("FAIL reset_hilo got %h_%h exp 0", bus.hi, bus.lo); end
        checks++; if ({bus.zero, bus.overflow, bus.illegal} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {bus.zero, bus.overflow, bus.illegal});
        end
    endtask

    task automatic test_add();
        issue(4'b0010, 32'd7, 32'd5);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL add_done got %b exp 1", bus.done); end
        checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL add_result got %h exp c", bus.result); end
        checks++; if ({bus.zero, bus.overflow, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL add_flags got %b exp 000", {bus.zero, bus.overflow, bus.busy});
        end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b exp 0", bus.done); end
        checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL add_hold got %h exp c", bus.result); end
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1; bus.op = 4'b0110; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk); #1;
        checks++; if ({bus.done, bus.zero} !== 2'b11 || bus.result !== '0) begin
            errors++; $display("FAIL sub_zero got done=%b zero=%b res=%h exp 1 1 0", bus.done, bus.zero, bus.result);
        end
        bus.op = 4'b0111; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
        @(posedge clk); #1;
        checks++; if ({bus.done, bus.zero} !== 2'b10 || bus.result !== 32'd1) begin
            errors++; $display("FAIL slt_neg got done=%b zero=%b res=%h exp 1 0 1", bus.done, bus.zero, bus.result);
        end
        bus.a = 32'd1; bus.b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin
            errors++; $display("FAIL slt_pos got res=%h zero=%b exp 0 1", bus.result, bus.zero);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_end got %b exp 0", bus.done); end
    endtask

    task automatic test_logic();
        issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        checks++; if (bus.result !== 32'h00F0_1200) begin errors++; $display("FAIL and got %h exp 00f01200", bus.result); end
        issue(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00);
        checks++; if (bus.result !== 32'hFFF0_FF34) begin errors++; $display("FAIL or got %h exp fff0ff34", bus.result); end
        issue(4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00);
        checks++; if (bus.result !== 32'h000F_00CB) begin errors++; $display("FAIL nor got %h exp 000f00cb", bus.result); end
    endtask

    task automatic test_overflow_illegal();
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
        checks++; if (bus.result !== 32'h8000_0000 || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL add_ovf got res=%h ovf=%b exp 80000000 1", bus.result, bus.overflow);
        end
        issue(4'b0110, 32'h8000_0000, 32'd1);
        checks++; if (bus.result !== 32'h7FFF_FFFF || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL sub_ovf got res=%h ovf=%b exp 7fffffff 1", bus.result, bus.overflow);
        end
        issue(4'b0101, 32'h1234_5678, 32'd9);
        checks++; if ({bus.done, bus.illegal, bus.overflow, bus.zero} !== 4'b1101 || bus.result !== '0) begin
            errors++; $display("FAIL illegal got d/i/o/z=%b res=%h exp 1101 0",
                               {bus.done, bus.illegal, bus.overflow, bus.zero}, bus.result);
        end
        issue(4'b0010, 32'd1, 32'd1);
        checks++; if (bus.illegal !== 1'b0 || bus.result !== 32'd2) begin
            errors++; $display("FAIL illegal_clear got ill=%b res=%h exp 0 2", bus.illegal, bus.result);
        end
        checks++; if ({bus.hi, bus.lo} !== '0) begin errors++; $display("FAIL hilo_untouched got %h_%h exp 0", bus.hi, bus.lo); end
    endtask

    task automatic test_multu_big();
        int  lat = 0;
        int  busy_cnt = 0;
        bit  seen = 0;
        issue(4'b1000, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 40; i++) begin
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mul_timeout got no done exp done"); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
        checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 32", busy_cnt); end
        checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL mul_product got %h_%h exp 00000001_fffffffe", bus.hi, bus.lo);
        end
        checks++; if (bus.result !== 32'hFFFF_FFFE || {bus.zero, bus.overflow, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL mul_result got res=%h z/o/b=%b exp fffffffe 000",
                               bus.result, {bus.zero, bus.overflow, bus.busy});
        end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_multu_ignore();
        int dones = 0;
        issue(4'b1000, 32'd3, 32'd4);
        for (int i = 0; i < 45; i++) begin
            if (bus.done) dones++;
            if (i == 5) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_mid got %b exp 1", bus.busy); end
                bus.start = 1'b1; bus.op = 4'b0010; bus.a = 32'd1; bus.b = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL mul_ignore_dones got %0d exp 1", dones); end
        checks++; if (bus.lo !== 32'd12 || bus.hi !== 32'd0 || bus.result !== 32'd12) begin
            errors++; $display("FAIL mul_ignore_product got hi=%h lo=%h res=%h exp 0 c c", bus.hi, bus.lo, bus.result);
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones = 0;
        issue(4'b1000, 32'd5, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL rstmul_busy_done got %b exp 00", {bus.busy, bus.done});
        end
        checks++; if (bus.result !== '0 || bus.hi !== '0 || bus.lo !== '0) begin
            errors++; $display("FAIL rstmul_outputs got res=%h hi=%h lo=%h exp 0", bus.result, bus.hi, bus.lo);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) dones++;
            @(posedge clk); #1;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rstmul_no_done got %0d exp 0", dones); end
        issue(4'b0010, 32'd2, 32'd2);
        checks++; if (bus.result !== 32'd4 || bus.done !== 1'b1) begin
            errors++; $display("FAIL rstmul_add got res=%h done=%b exp 4 1", bus.result, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_logic();
        test_overflow_illegal();
        test_multu_big();
        test_multu_ignore();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
